pipelined_prefix_offset: RTL and testbench

Fully pipelined successor to the iterative laggy prefix counter. Each request carries its own bitmask, matched position and weight. The block returns the masked popcount offset, which is the count of 1s at or below the position (inclusive) or strictly below it (exclusive). Sits between the bitmask AND/match stage and the weight-correction accumulator. It sustains one request per cycle with valid/ready backpressure on both sides, instead of one every 9 cycles.

---
 rtl/prefix_pkg.sv | 41 ++++
 rtl/prefix_req_fifo.sv | 49 ++++
 rtl/pipelined_prefix_offset.sv | 139 +++++++++++++
 tb/tb_pipelined_prefix_offset.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefix_pkg.sv
// Shared widths, the request record and the per-chunk masked popcount helper
// used by the pipelined prefix offset block.
package prefix_pkg;

    localparam int DEF_BITMASK_WIDTH = 128;
    localparam int DEF_NUM_ADDERS    = 16;
    localparam int DEF_WEIGHT_WIDTH  = 8;
    localparam int DEF_FIFO_DEPTH    = 8;

    localparam int POS_W     = $clog2(DEF_BITMASK_WIDTH);
    localparam int OFF_W     = POS_W + 1;
    localparam int L         = $clog2(DEF_NUM_ADDERS);
    localparam int CHUNK_MAX = 64;

    typedef struct packed {
        logic [DEF_BITMASK_WIDTH-1:0] bitmask;
        logic [POS_W-1:0]             position;
        logic [DEF_WEIGHT_WIDTH-1:0]  weight;
        logic                         exclusive;
    } req_t;

    // Counts set bits of one chunk whose absolute index lies at/below position
    // (or strictly below when exclusive). Chunk bits above chunk_size are ignored.
    function automatic int unsigned masked_chunk_count(
        input logic [CHUNK_MAX-1:0] chunk,
        input int unsigned          chunk_size,
        input int unsigned          base,
        input int unsigned          position,
        input logic                 exclusive
    );
        int unsigned cnt;
        cnt = 0;
        for (int unsigned j = 0; j < CHUNK_MAX; j++) begin
            if ((j < chunk_size) && chunk[j] &&
                (exclusive ? ((base + j) < position) : ((base + j) <= position)))
                cnt = cnt + 1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prefix_req_fifo.sv
// Ingress request FIFO: first-word-fall-through read, async-reset pointer pair
// with an extra wrap bit so full/empty/count fall out of a pointer difference.
module prefix_req_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_full  = (o_count == (AW+1)'(DEPTH));
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/pipelined_prefix_offset.sv
// Masked popcount offset, one request per cycle: FIFO -> per-chunk counts ->
// pairwise adder tree; all stages share one advance enable driven by the output.
module pipelined_prefix_offset
    import prefix_pkg::*;
#(
    parameter  int BITMASK_WIDTH = DEF_BITMASK_WIDTH,
    parameter  int NUM_ADDERS    = DEF_NUM_ADDERS,
    parameter  int WEIGHT_WIDTH  = DEF_WEIGHT_WIDTH,
    parameter  int FIFO_DEPTH    = DEF_FIFO_DEPTH,
    localparam int CW            = BITMASK_WIDTH / NUM_ADDERS,
    localparam int PW            = $clog2(BITMASK_WIDTH),
    localparam int OW            = PW + 1,
    localparam int LV            = $clog2(NUM_ADDERS),
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITMASK_WIDTH-1:0] in_bitmask,
    input  logic [PW-1:0]            in_position,
    input  logic [WEIGHT_WIDTH-1:0]  in_weight,
    input  logic                     in_exclusive,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OW-1:0]            out_offset,
    output logic [PW-1:0]            out_position,
    output logic [WEIGHT_WIDTH-1:0]  out_weight,
    output logic                     out_hit,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     busy
);

    localparam int REQ_W = BITMASK_WIDTH + PW + WEIGHT_WIDTH + 1;

    logic                     w_adv, w_pop, w_push, w_full, w_empty;
    logic [REQ_W-1:0]         w_head;
    logic [BITMASK_WIDTH-1:0] w_head_mask;
    logic [PW-1:0]            w_head_pos;
    logic [WEIGHT_WIDTH-1:0]  w_head_wgt;
    logic                     w_head_excl;
    logic [OW-1:0]            w_leaf [NUM_ADDERS];

    logic [LV+1:1]            r_vld;
    logic [PW-1:0]            r_pos [LV+1:1];
    logic [WEIGHT_WIDTH-1:0]  r_wgt [LV+1:1];
    logic                     r_hit [LV+1:1];

    assign out_valid = r_vld[LV+1];
    assign w_adv     = !r_vld[LV+1] || out_ready;
    assign w_pop     = w_adv && !w_empty;
    assign w_push    = in_valid && !w_full;
    assign in_ready  = !w_full;
    assign busy      = !w_empty || (|r_vld);

    prefix_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({in_bitmask, in_position, in_weight, in_exclusive}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    assign {w_head_mask, w_head_pos, w_head_wgt, w_head_excl} = w_head;

    always_comb begin
        logic [CHUNK_MAX-1:0] v_chunk;
        v_chunk = '0;
        for (int i = 0; i < NUM_ADDERS; i++) begin
            v_chunk         = '0;
            v_chunk[CW-1:0] = w_head_mask[i*CW +: CW];
            w_leaf[i]       = OW'(masked_chunk_count(v_chunk, CW, i*CW,
                                                     32'(w_head_pos), w_head_excl));
        end
    end

    // Sideband rides alongside the tree; bubbles keep their slot (valid=0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            for (int s = 1; s <= LV + 1; s++) begin
                r_pos[s] <= '0;
                r_wgt[s] <= '0;
                r_hit[s] <= 1'b0;
            end
        end else if (w_adv) begin
            r_vld <= {r_vld[LV:1], w_pop};
            if (w_pop) begin
                r_pos[1] <= w_head_pos;
                r_wgt[1] <= w_head_wgt;
                r_hit[1] <= w_head_mask[w_head_pos];
            end
            for (int s = 1; s <= LV; s++) begin
                if (r_vld[s]) begin
                    r_pos[s+1] <= r_pos[s];
                    r_wgt[s+1] <= r_wgt[s];
                    r_hit[s+1] <= r_hit[s];
                end
            end
        end
    end

    for (genvar s = 0; s <= LV; s++) begin : g_lvl
        localparam int N = NUM_ADDERS >> s;
        logic [OW-1:0] r_sum [N];

        if (s == 0) begin : g_leaf
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < N; j++) r_sum[j] <= '0;
                end else if (w_pop) begin
                    for (int j = 0; j < N; j++) r_sum[j] <= w_leaf[j];
                end
            end
        end else begin : g_add
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < N; j++) r_sum[j] <= '0;
                end else if (w_adv && r_vld[s]) begin
                    for (int j = 0; j < N; j++)
                        r_sum[j] <= g_lvl[s-1].r_sum[2*j] + g_lvl[s-1].r_sum[2*j+1];
                end
            end
        end
    end

    assign out_offset   = g_lvl[LV].r_sum[0];
    assign out_position = r_pos[LV+1];
    assign out_weight   = r_wgt[LV+1];
    assign out_hit      = r_hit[LV+1];

endmodule

// File: tb/tb_pipelined_prefix_offset.sv
// Bench for pipelined_prefix_offset: directed vector table, random streams
// against a whole-vector popcount model, stall/capacity and reset sequences.
module tb_pipelined_prefix_offset;
    import prefix_pkg::*;

    localparam int BW    = DEF_BITMASK_WIDTH;
    localparam int WW    = DEF_WEIGHT_WIDTH;
    localparam int CNT_W = $clog2(DEF_FIFO_DEPTH) + 1;
    localparam int LAT   = L + 1;
    localparam int CAP   = DEF_FIFO_DEPTH + L + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [BW-1:0]    in_bitmask = '0;
    logic [POS_W-1:0] in_position = '0;
    logic [WW-1:0]    in_weight = '0;
    logic             in_exclusive = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OFF_W-1:0] out_offset;
    logic [POS_W-1:0] out_position;
    logic [WW-1:0]    out_weight;
    logic             out_hit;
    logic [CNT_W-1:0] fifo_count;
    logic             busy;

    always #5 clk = ~clk;

    pipelined_prefix_offset dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bitmask   (in_bitmask),
        .in_position  (in_position),
        .in_weight    (in_weight),
        .in_exclusive (in_exclusive),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_offset   (out_offset),
        .out_position (out_position),
        .out_weight   (out_weight),
        .out_hit      (out_hit),
        .fifo_count   (fifo_count),
        .busy         (busy)
    );

    typedef struct {
        logic [BW-1:0] mask;
        int            pos;
        bit            excl;
        int            exp_off;
        bit            exp_hit;
    } vec_t;

    typedef struct {
        int off;
        int pos;
        int wgt;
        bit hit;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;
    int   n_acc, n_out, gaps, cyc, last_cyc;
    bit   first_out;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int ref_offset(input logic [BW-1:0] m, input int pos, input bit excl);
        int c;
        c = 0;
        for (int b = 0; b < BW; b++)
            if (m[b] && (b < pos || (b == pos && !excl))) c++;
        return c;
    endfunction

    task automatic rand_req();
        for (int k = 0; k < BW / 32; k++) in_bitmask[k*32 +: 32] = $urandom();
        in_position  = POS_W'($urandom_range(0, BW - 1));
        in_weight    = WW'($urandom());
        in_exclusive = 1'($urandom_range(0, 1));
    endtask

    // Handshakes are sampled mid-cycle; the transfer happens on the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (mon_en && !rst) begin
            if (in_valid && in_ready) begin
                n_acc++;
                sb.push_back('{ref_offset(in_bitmask, int'(in_position), in_exclusive),
                               int'(in_position), int'(in_weight), in_bitmask[in_position]});
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (!first_out && cyc != last_cyc + 1) gaps++;
                first_out = 0;
                last_cyc  = cyc;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stream_extra: got result offset %0d, expected none", out_offset);
                end else begin
                    e = sb.pop_front();
                    check("stream_offset", out_offset, e.off);
                    check("stream_position", out_position, e.pos);
                    check("stream_weight", out_weight, e.wgt);
                    check("stream_hit", out_hit, e.hit);
                end
            end
        end
    end

    task automatic phase_start();
        n_acc = 0; n_out = 0; gaps = 0; first_out = 1;
    endtask

    task automatic send_one(input logic [BW-1:0] m, input int pos, input bit excl,
                            input int wgt, output int lat);
        in_bitmask   = m;
        in_position  = POS_W'(pos);
        in_exclusive = excl;
        in_weight    = WW'(wgt);
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t          vecs[10];
        logic [BW-1:0] aa, ones, b0;
        int            lat;
        logic [OFF_W-1:0] s_off;
        logic [POS_W-1:0] s_pos;
        logic [WW-1:0]    s_wgt;
        bit            acc;

        aa   = {64{2'b10}};
        ones = '1;
        b0   = '0;
        b0[0] = 1'b1;
        vecs[0] = '{ones, 127, 1'b0, 128, 1'b1};
        vecs[1] = '{aa,    64, 1'b0,  32, 1'b0};
        vecs[2] = '{aa,    65, 1'b0,  33, 1'b1};
        vecs[3] = '{aa,    65, 1'b1,  32, 1'b1};
        vecs[4] = '{b0,     0, 1'b1,   0, 1'b1};
        vecs[5] = '{b0,     0, 1'b0,   1, 1'b1};
        vecs[6] = '{ones, 127, 1'b1, 127, 1'b1};
        vecs[7] = '{ones,   0, 1'b1,   0, 1'b1};
        vecs[8] = '{'0,   100, 1'b0,   0, 1'b0};
        vecs[9] = '{aa,   127, 1'b0,  64, 1'b1};

        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_offset", out_offset, 0);
        check("reset_out_hit", out_hit, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i].mask, vecs[i].pos, vecs[i].excl, i * 17 + 3, lat);
            check($sformatf("vec%0d_latency", i), lat, LAT);
            check($sformatf("vec%0d_offset", i), out_offset, vecs[i].exp_off);
            check($sformatf("vec%0d_hit", i), out_hit, vecs[i].exp_hit);
            check($sformatf("vec%0d_position", i), out_position, vecs[i].pos);
            check($sformatf("vec%0d_weight", i), out_weight, i * 17 + 3);
            @(posedge clk); #1;
            check($sformatf("vec%0d_drained", i), out_valid, 0);
        end

        // 20 back-to-back random requests with the consumer always ready
        phase_start();
        mon_en = 1;
        for (int i = 0; i < 20; i++) begin
            rand_req();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("burst_accepted", n_acc, 20);
        check("burst_results", n_out, 20);
        check("burst_gaps", gaps, 0);
        check("burst_idle", busy, 0);

        // permanent stall with continuous input, then drain
        phase_start();
        out_ready = 1'b0;
        rand_req();
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) rand_req();
        end
        check("stall_accepted", n_acc, CAP);
        check("stall_in_ready", in_ready, 0);
        check("stall_fifo_count", fifo_count, DEF_FIFO_DEPTH);
        check("stall_out_valid", out_valid, 1);
        s_off = out_offset; s_pos = out_position; s_wgt = out_weight;
        repeat (4) @(posedge clk);
        #1;
        check("stall_hold_offset", out_offset, s_off);
        check("stall_hold_position", out_position, s_pos);
        check("stall_hold_weight", out_weight, s_wgt);
        check("stall_hold_accepted", n_acc, CAP);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("drain_results", n_out, CAP);
        check("drain_gaps", gaps, 0);
        check("drain_scoreboard_empty", sb.size(), 0);
        check("drain_fifo_count", fifo_count, 0);
        check("drain_busy", busy, 0);

        // reset with 3 queued and 4 in flight
        mon_en = 0;
        sb.delete();
        out_ready = 1'b0;
        rand_req();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            rand_req();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("prereset_fifo_count", fifo_count, 3);
        check("prereset_out_valid", out_valid, 1);
        check("prereset_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_fifo_count", fifo_count, 0);
        check("midreset_busy", busy, 0);
        check("midreset_in_ready", in_ready, 1);
        check("midreset_out_offset", out_offset, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_one(aa, 65, 1'b0, 99, lat);
        check("postreset_latency", lat, LAT);
        check("postreset_offset", out_offset, 33);
        check("postreset_hit", out_hit, 1);
        check("postreset_weight", out_weight, 99);
        @(posedge clk); #1;
        check("postreset_no_stale", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
